// File: rtl/mul_sched.sv
// mul_sched: sequencer for a single MUL stage.
//
// Takes a job descriptor (iterations x reads-per-iteration), issues a
// one-cycle configure pulse to the MUL, feeds it one weight per iteration
// from a small local FIFO, and gates the MUL avail so the MUL weight register
// can only change between iterations. A one-cycle done pulse ends each job.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   job_valid_in/avail_out   job handshake (accepted in IDLE only)
//   job_num_iters_in/reads   job descriptor counts
//   w_data_in/valid_in       weight stream into the local FIFO
//   w_avail_out              FIFO can take a weight this cycle
//   mul_configure_out        one-cycle configure pulse to MUL
//   mul_num_iters/reads_out  counts of the current job
//   mul_weight_data/valid    weight load strobe to MUL
//   mul_op_in                MUL performed a read this cycle
//   out_avail_in             downstream avail
//   mul_avail_out            gated avail to MUL
//   busy_out, done_out       job status
//   stall_cycles_out         stall counter (only with MUL_SCHED_PERF_EN)
//
// Handshakes: a transfer happens on a rising clk edge where the sender's
// valid and the receiver's avail are both high; valid never waits on avail.
//
// Build option: define MUL_SCHED_PERF_EN to include the stall counter;
// otherwise stall_cycles_out is tied to zero.
module mul_sched #(
  parameter int DATA_WIDTH             = 8,
  parameter int LOG_MAX_ITERS          = 16,
  parameter int LOG_MAX_READS_PER_ITER = 16,
  parameter int WBUF_SLOTS             = 4,
  parameter int LOG_WBUF_SLOTS         = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              job_valid_in,
  output logic                              job_avail_out,
  input  logic [LOG_MAX_ITERS-1:0]          job_num_iters_in,
  input  logic [LOG_MAX_READS_PER_ITER-1:0] job_num_reads_in,
  input  logic [DATA_WIDTH-1:0]             w_data_in,
  input  logic                              w_valid_in,
  output logic                              w_avail_out,
  output logic                              mul_configure_out,
  output logic [LOG_MAX_ITERS-1:0]          mul_num_iters_out,
  output logic [LOG_MAX_READS_PER_ITER-1:0] mul_num_reads_out,
  output logic [DATA_WIDTH-1:0]             mul_weight_data_out,
  output logic                              mul_weight_valid_out,
  input  logic                              mul_op_in,
  input  logic                              out_avail_in,
  output logic                              mul_avail_out,
  output logic                              busy_out,
  output logic                              done_out,
  output logic [31:0]                       stall_cycles_out
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CONFIG = 3'd1;
  localparam logic [2:0] S_WAIT_W = 3'd2;
  localparam logic [2:0] S_LOAD_W = 3'd3;
  localparam logic [2:0] S_RUN    = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [LOG_MAX_ITERS-1:0]          ITERS_ONE = {{(LOG_MAX_ITERS-1){1'b0}}, 1'b1};
  localparam logic [LOG_MAX_READS_PER_ITER-1:0] READS_ONE = {{(LOG_MAX_READS_PER_ITER-1){1'b0}}, 1'b1};
  localparam logic [LOG_WBUF_SLOTS:0]           CNT_ONE   = {{LOG_WBUF_SLOTS{1'b0}}, 1'b1};
  localparam logic [LOG_WBUF_SLOTS:0]           CNT_FULL  = (LOG_WBUF_SLOTS+1)'(WBUF_SLOTS);
  localparam logic [LOG_WBUF_SLOTS-1:0]         PTR_ONE   = {{(LOG_WBUF_SLOTS-1){1'b0}}, 1'b1};

  logic [2:0]                        r_state;
  logic [LOG_MAX_ITERS-1:0]          r_num_iters;
  logic [LOG_MAX_READS_PER_ITER-1:0] r_num_reads;
  logic [LOG_MAX_ITERS-1:0]          r_iters_left;
  logic [LOG_MAX_READS_PER_ITER-1:0] r_reads_left;

  logic [DATA_WIDTH-1:0]     r_wbuf [WBUF_SLOTS];
  logic [LOG_WBUF_SLOTS-1:0] r_wr_ptr;
  logic [LOG_WBUF_SLOTS-1:0] r_rd_ptr;
  logic [LOG_WBUF_SLOTS:0]   r_count;

  logic w_pop;
  logic w_push;
  logic w_empty;
  logic w_full;

  assign w_pop   = (r_state == S_LOAD_W);
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_FULL);
  // The pop in LOAD_W frees a slot in the same cycle, so a full FIFO may
  // still take a weight then (push and pop together leave the count at full).
  assign w_avail_out = !w_full || w_pop;
  assign w_push      = w_valid_in && w_avail_out;

  assign job_avail_out        = (r_state == S_IDLE);
  assign busy_out             = (r_state != S_IDLE);
  assign mul_configure_out    = (r_state == S_CONFIG);
  assign done_out             = (r_state == S_DONE);
  assign mul_weight_valid_out = w_pop;
  assign mul_weight_data_out  = w_pop ? r_wbuf[r_rd_ptr] : '0;
  // Avail only in RUN: it drops the cycle after the last op of an
  // iteration, so the MUL cannot read across a weight change.
  assign mul_avail_out        = (r_state == S_RUN) && out_avail_in;
  assign mul_num_iters_out    = r_num_iters;
  assign mul_num_reads_out    = r_num_reads;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_num_iters  <= '0;
      r_num_reads  <= '0;
      r_iters_left <= '0;
      r_reads_left <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (job_valid_in) begin
            r_num_iters <= job_num_iters_in;
            r_num_reads <= job_num_reads_in;
            if (job_num_iters_in == '0 || job_num_reads_in == '0) r_state <= S_DONE;
            else                                                  r_state <= S_CONFIG;
          end
        end
        S_CONFIG: begin
          r_iters_left <= r_num_iters;
          r_reads_left <= r_num_reads;
          r_state      <= w_empty ? S_WAIT_W : S_LOAD_W;
        end
        S_WAIT_W: begin
          if (!w_empty) r_state <= S_LOAD_W;
        end
        S_LOAD_W: begin
          r_state <= S_RUN;
        end
        S_RUN: begin
          if (mul_op_in) begin
            if (r_reads_left == READS_ONE) begin
              if (r_iters_left == ITERS_ONE) begin
                r_state <= S_DONE;
              end else begin
                r_iters_left <= r_iters_left - ITERS_ONE;
                r_reads_left <= r_num_reads;
                r_state      <= w_empty ? S_WAIT_W : S_LOAD_W;
              end
            end else begin
              r_reads_left <= r_reads_left - READS_ONE;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Weight FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_wbuf[r_wr_ptr] <= w_data_in;
  end

`ifdef MUL_SCHED_PERF_EN
  logic [31:0] r_stall;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stall <= '0;
    end else if (r_state == S_IDLE && job_valid_in) begin
      r_stall <= '0;
    end else if ((r_state == S_WAIT_W || (r_state == S_RUN && !out_avail_in)) &&
                 r_stall != 32'hFFFF_FFFF) begin
      r_stall <= r_stall + 32'd1;
    end
  end

  assign stall_cycles_out = r_stall;
`else
  assign stall_cycles_out = '0;
`endif

endmodule

// File: tb/tb_mul_sched.sv
module tb_mul_sched;

  logic        clk;
  logic        rst;
  logic        job_valid_in;
  logic        job_avail_out;
  logic [15:0] job_num_iters_in;
  logic [15:0] job_num_reads_in;
  logic [7:0]  w_data_in;
  logic        w_valid_in;
  logic        w_avail_out;
  logic        mul_configure_out;
  logic [15:0] mul_num_iters_out;
  logic [15:0] mul_num_reads_out;
  logic [7:0]  mul_weight_data_out;
  logic        mul_weight_valid_out;
  logic        mul_op_in;
  logic        out_avail_in;
  logic        mul_avail_out;
  logic        busy_out;
  logic        done_out;
  logic [31:0] stall_cycles_out;

  // MUL model: reads whenever offered (op_mode=1) or a forced level.
  logic op_mode;
  logic op_force;
  assign mul_op_in = op_mode ? mul_avail_out : op_force;

  mul_sched dut (
    .clk                  (clk),
    .rst                  (rst),
    .job_valid_in         (job_valid_in),
    .job_avail_out        (job_avail_out),
    .job_num_iters_in     (job_num_iters_in),
    .job_num_reads_in     (job_num_reads_in),
    .w_data_in            (w_data_in),
    .w_valid_in           (w_valid_in),
    .w_avail_out          (w_avail_out),
    .mul_configure_out    (mul_configure_out),
    .mul_num_iters_out    (mul_num_iters_out),
    .mul_num_reads_out    (mul_num_reads_out),
    .mul_weight_data_out  (mul_weight_data_out),
    .mul_weight_valid_out (mul_weight_valid_out),
    .mul_op_in            (mul_op_in),
    .out_avail_in         (out_avail_in),
    .mul_avail_out        (mul_avail_out),
    .busy_out             (busy_out),
    .done_out             (done_out),
    .stall_cycles_out     (stall_cycles_out)
  );

  // ---------------- clock / reset block ----------------
  int cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout need=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  // Event words: {8'h01, iters, reads} for configure, {8'h03, op count} for done.
  logic [39:0] exp_q[$];
  logic [7:0]  wexp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [39:0] got, input logic [39:0] need);
    total++;
    if (got !== need) begin
      bad++;
      $display("FAIL %s: got=%0h need=%0h (cyc %0d)", name, got, need, cyc);
    end
  endtask

  task automatic pop_chk(input string name, input logic [39:0] got);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: got=%0h need=no_event (cyc %0d)", name, got, cyc);
    end else begin
      chk(name, got, exp_q.pop_front());
    end
  endtask

  // ---------------- monitor ----------------
  int acc_cyc     = 0;
  int cfg_cyc     = 0;
  int first_w_cyc = -1;
  int last_op_cyc = 0;
  int ops_seen    = 0;
  bit in_job      = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      in_job = 1'b0;
    end else begin
      if (job_valid_in && job_avail_out) begin
        acc_cyc  = cyc;
        ops_seen = 0;
      end
      if (mul_configure_out) begin
        cfg_cyc     = cyc;
        in_job      = 1'b1;
        ops_seen    = 0;
        first_w_cyc = -1;
        chk("cfg_latency", 40'(cyc), 40'(acc_cyc + 1));
        pop_chk("cfg_event", {8'h01, mul_num_iters_out, mul_num_reads_out});
      end
      if (mul_weight_valid_out) begin
        chk("w_in_job", 40'(in_job), 40'd1);
        if (first_w_cyc < 0) first_w_cyc = cyc;
        if (wexp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL w_unexpected: got=%0h need=no_weight (cyc %0d)", mul_weight_data_out, cyc);
        end else begin
          chk("w_data", 40'(mul_weight_data_out), 40'(wexp_q.pop_front()));
        end
      end
      if (mul_op_in && mul_avail_out) begin
        ops_seen++;
        last_op_cyc = cyc;
      end
      if (done_out) begin
        pop_chk("done_event", {8'h03, 32'(ops_seen)});
        chk("done_latency", 40'(cyc), 40'(ops_seen > 0 ? last_op_cyc + 1 : acc_cyc + 1));
        in_job = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_w(input logic [7:0] d);
    int n = 0;
    while (!w_avail_out && n < 100) begin tick(); n++; end
    if (n == 100) begin
      total++; bad++;
      $display("FAIL push_w_wait: got=timeout need=w_avail");
    end
    w_valid_in = 1'b1;
    w_data_in  = d;
    wexp_q.push_back(d);
    tick();
    w_valid_in = 1'b0;
  endtask

  task automatic send_job(input logic [15:0] it, input logic [15:0] rd);
    int n = 0;
    while (!job_avail_out && n < 100) begin tick(); n++; end
    if (n == 100) begin
      total++; bad++;
      $display("FAIL job_wait: got=timeout need=job_avail");
    end
    job_valid_in     = 1'b1;
    job_num_iters_in = it;
    job_num_reads_in = rd;
    if (it != 0 && rd != 0) exp_q.push_back({8'h01, it, rd});
    exp_q.push_back({8'h03, 32'(32'(it) * 32'(rd) * ((it != 0 && rd != 0) ? 1 : 0))});
    tick();
    job_valid_in = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy_out && n < 300) begin tick(); n++; end
    chk(name, 40'(busy_out), 40'd0);
  endtask

  task automatic wait_ops(input int k);
    int n = 0;
    while (ops_seen < k && n < 300) begin tick(); n++; end
    chk("wait_ops", 40'(ops_seen >= k), 40'd1);
  endtask

  task automatic queues_empty(input string name);
    chk(name, 40'(exp_q.size() + wexp_q.size()), 40'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_job_avail"}, 40'(job_avail_out), 40'd1);
    chk({name, "_w_avail"},   40'(w_avail_out), 40'd1);
    chk({name, "_quiet"}, 40'({mul_configure_out, mul_weight_valid_out, mul_avail_out,
                               busy_out, done_out}), 40'd0);
    chk({name, "_counts"}, 40'({mul_num_iters_out, mul_num_reads_out}), 40'd0);
    chk({name, "_wdata"}, 40'(mul_weight_data_out), 40'd0);
    chk({name, "_stall"}, 40'(stall_cycles_out), 40'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0; job_valid_in = 1'b0; job_num_iters_in = '0; job_num_reads_in = '0;
    w_data_in = '0; w_valid_in = 1'b0; out_avail_in = 1'b1;
    op_mode = 1'b1; op_force = 1'b0;
    tick(); tick();
    check_reset_outputs("reset");
    rst = 1'b1;
    tick();

    // T1: two iterations of three reads, both weights preloaded.
    push_w(8'h05);
    push_w(8'h07);
    send_job(16'd2, 16'd3);
    wait_idle("t1_idle");
    chk("t1_first_w", 40'(first_w_cyc), 40'(cfg_cyc + 1));
    chk("t1_busy_after", 40'(busy_out), 40'd0);
    queues_empty("t1_queues");

    // T2: no weights buffered; second weight arrives late.
    send_job(16'd2, 16'd3);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_gate_wait1", 40'(mul_avail_out), 40'd0);
    end
    push_w(8'h05);
    wait_ops(3);
    op_mode  = 1'b0;
    op_force = 1'b1;  // ops while waiting for a weight must be ignored
    for (int i = 0; i < 5; i++) begin
      chk("t2_gate_wait2", 40'(mul_avail_out), 40'd0);
      tick();
    end
    op_mode  = 1'b1;
    op_force = 1'b0;
    push_w(8'h07);
    wait_idle("t2_idle");
`ifdef MUL_SCHED_PERF_EN
    chk("t2_stall_min", 40'(stall_cycles_out >= 32'd5), 40'd1);
`else
    chk("t2_stall_tied", 40'(stall_cycles_out), 40'd0);
`endif
    queues_empty("t2_queues");

    // T3: zero-iteration job must not configure or pop; buffered weight stays.
    push_w(8'h09);
    send_job(16'd0, 16'd4);
    chk("t3_no_cfg", 40'(mul_configure_out), 40'd0);
    wait_idle("t3_idle");
    chk("t3_w_kept", 40'(wexp_q.size()), 40'd1);
    send_job(16'd1, 16'd1);
    wait_idle("t3b_idle");
    queues_empty("t3_queues");

    // T4: full FIFO, ignored push while full, push+pop together in LOAD_W.
    push_w(8'h11);
    push_w(8'h22);
    push_w(8'h33);
    push_w(8'h44);
    chk("t4_full", 40'(w_avail_out), 40'd0);
    w_valid_in = 1'b1;
    w_data_in  = 8'h66;
    tick();
    w_valid_in = 1'b0;
    send_job(16'd5, 16'd1);
    tick();
    chk("t4_avail_on_pop", 40'(w_avail_out), 40'd1);
    w_valid_in = 1'b1;
    w_data_in  = 8'h55;
    wexp_q.push_back(8'h55);
    tick();
    w_valid_in = 1'b0;
    chk("t4_still_full", 40'(w_avail_out), 40'd0);
    wait_idle("t4_idle");
    chk("t4_first_w", 40'(first_w_cyc), 40'(cfg_cyc + 1));
    queues_empty("t4_queues");

    // T5: reset in the middle of RUN aborts without done and empties the FIFO.
    push_w(8'h05);
    push_w(8'h07);
    send_job(16'd2, 16'd3);
    wait_ops(2);
    rst = 1'b0;
    exp_q.delete();
    wexp_q.delete();
    tick();
    check_reset_outputs("t5_reset");
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_no_done", 40'(done_out), 40'd0);
    end
    push_w(8'h0A);
    send_job(16'd1, 16'd2);
    wait_idle("t5_idle");
    queues_empty("t5_queues");

    // T6: downstream avail toggling during RUN.
    push_w(8'h05);
    push_w(8'h07);
    send_job(16'd2, 16'd3);
    begin
      int n = 0;
      while (busy_out && n < 200) begin
        out_avail_in = (n % 2 == 0);
        tick();
        if (!out_avail_in) chk("t6_gate_low", 40'(mul_avail_out), 40'd0);
        n++;
      end
      chk("t6_idle", 40'(busy_out), 40'd0);
    end
    out_avail_in = 1'b1;
    tick();
    queues_empty("t6_queues");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_sched.md
Name: mul_sched

Overview:
- Sequencer for one MUL stage.
- Accepts a job descriptor (iterations x reads-per-iteration) and issues the MUL configure pulse.
- Streams one weight per iteration from a small local weight FIFO.
- Gates the MUL output-avail so the weight register never changes mid-iteration. Signals job completion.
- Sits between the layer control FSM/weight reader and the MUL instance.

Parameters:
- DATA_WIDTH, 8, weight width.
- LOG_MAX_ITERS, 16, width of iteration count.
- LOG_MAX_READS_PER_ITER, 16, width of reads-per-iteration count.
- WBUF_SLOTS, 4, weight FIFO depth.
- LOG_WBUF_SLOTS, 2, log2(WBUF_SLOTS).

Ports:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-low reset.
- job_valid_in, in, 1, job descriptor valid.
- job_avail_out, out, 1, scheduler can accept a job (state IDLE).
- job_num_iters_in, in, LOG_MAX_ITERS, iterations for the job.
- job_num_reads_in, in, LOG_MAX_READS_PER_ITER, reads per iteration.
- w_data_in, in, DATA_WIDTH, weight (one per iteration, in order).
- w_valid_in, in, 1, weight valid.
- w_avail_out, out, 1, weight FIFO not full.
- mul_configure_out, out, 1, one-cycle configure pulse to MUL.
- mul_num_iters_out, out, LOG_MAX_ITERS, registered job iterations.
- mul_num_reads_out, out, LOG_MAX_READS_PER_ITER, registered reads per iteration.
- mul_weight_data_out, out, DATA_WIDTH, weight to MUL.
- mul_weight_valid_out, out, 1, weight load strobe to MUL.
- mul_op_in, in, 1, MUL performed a read this cycle (MUL valid_out).
- out_avail_in, in, 1, downstream avail.
- mul_avail_out, out, 1, gated avail to MUL avail_in.
- busy_out, out, 1, job in progress.
- done_out, out, 1, one-cycle pulse at job end.
- stall_cycles_out, out, 32, perf counter (see Optional Feature).

Behaviour:
- Reset (rst=0 at clk edge): state IDLE; counters 0; weight FIFO emptied. All outputs 0 except job_avail_out=1 and w_avail_out=1. Reset mid-job aborts without a done pulse.

States: IDLE, CONFIG, WAIT_W, LOAD_W, RUN, DONE.
- IDLE: job_avail_out=1. Accept on job_valid_in and latch both counts.
  - Either count 0 -> DONE (no configure issued).
  - Otherwise -> CONFIG.
- CONFIG (1 cycle): mul_configure_out=1; mul_num_* outputs hold latched values from CONFIG until the next job. Set iters_left=num_iters, reads_left=num_reads. Next state: LOAD_W if FIFO non-empty, else WAIT_W.
- WAIT_W: mul_avail_out=0; -> LOAD_W when FIFO non-empty.
- LOAD_W (1 cycle): mul_weight_valid_out=1, mul_weight_data_out=FIFO head, pop FIFO; -> RUN.
- RUN: mul_avail_out=out_avail_in (all other states drive 0). Each mul_op_in decrements reads_left.
  - mul_op_in with reads_left==1, iters_left>1: iters_left-1, reads_left reloads num_reads, next state WAIT_W/LOAD_W (same rule as CONFIG).
  - mul_op_in with reads_left==1, iters_left==1: -> DONE.
  - No extra op can slip through: gate closes the cycle after the last op.
- DONE (1 cycle): done_out=1; -> IDLE.
- busy_out=1 in every state except IDLE.

Latency and ordering:
- Job accepted at cycle t -> configure at t+1 -> weight load at t+2 (if weight buffered) -> first op possible at t+3.
- Iteration switch costs 1 cycle if the next weight is buffered.

Weight FIFO:
- Push when w_valid_in & w_avail_out; w_valid_in while full is ignored.
- Simultaneous push and pop allowed, including when full. Count unchanged.
- Weights may be preloaded in IDLE and may carry over into the next job.

Other rules:
- mul_op_in outside RUN is ignored.
- Counters compare to 1 (never underflow); max counts are 2^W-1.

Optional Feature:
- MUL_SCHED_PERF_EN defined: stall_cycles_out is a 32-bit counter, cleared on reset and on job accept. Counts cycles in WAIT_W, plus cycles in RUN with out_avail_in=0. Saturates at 2^32-1. Holds its value after DONE.
- Not defined: stall_cycles_out is tied to 0 and no counter logic exists.

Test Plan:
- Job iters=2, reads=3; weights 0x05,0x07 preloaded; out_avail_in=1; mul_op_in=mul_avail_out -> configure 1 cycle after accept; weight strobes 0x05 then 0x07; exactly 6 ops; done_out 1 cycle after the 6th op; busy_out=0 afterwards.
- Same job with no weights preloaded; weight 0x07 supplied 5 cycles late -> mul_avail_out=0 throughout WAIT_W; no op before second LOAD_W; with MUL_SCHED_PERF_EN, stall_cycles_out>=5.
- Job iters=0, reads=4 -> no configure, no weight pop; done_out at t+1; FIFO count unchanged.
- Fill FIFO (4 weights), then push plus LOAD_W pop in the same cycle -> count stays 4; w_avail_out=0; no data lost or duplicated.
- rst=0 during RUN after 2 of 6 ops -> next cycle: IDLE, FIFO empty, mul_avail_out=0, done_out never asserted; new job runs normally.
- out_avail_in toggled 1,0,1,0 during RUN -> mul_avail_out follows it; ops counted only on mul_op_in; total still iters*reads=6.
